// File: rtl/exception_cp0.sv
// CP0 exception controller: Status/Cause/EPC registers plus a flush/redirect
// sequencer that squashes the pipeline and steers the PC on exception or ERET.
module exception_cp0 #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] handler_address,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        exl
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [2:0] CNT_LAST   = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        status_ie;
  logic        status_exl;
  logic [4:0]  cause_code;
  logic [31:0] epc;
  logic [31:0] target;
  logic        take_exc;
  logic        take_eret;

  // Requests are only honoured from IDLE; exception beats a coincident ERET.
  assign take_exc  = (state == S_IDLE) && exception;
  assign take_eret = (state == S_IDLE) && eret && !exception;

  // CP0 architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_ie  <= 1'b0;
      status_exl <= 1'b0;
      cause_code <= '0;
      epc        <= '0;
    end else begin
      if (mtc0_we && mtc0_addr == REG_STATUS) begin
        status_ie  <= mtc0_wdata[0];
        status_exl <= mtc0_wdata[1];
      end
      if (mtc0_we && mtc0_addr == REG_EPC) begin
        epc <= mtc0_wdata;
      end
      // NOTE: with non-blocking assignments the last write in the block wins,
      // so the exception/ERET updates below override a same-edge mtc0 write.
      if (take_exc) begin
        status_exl <= 1'b1;
        cause_code <= exc_code;
        if (!status_exl) begin
          epc <= exc_pc;
        end
      end else if (take_eret) begin
        status_exl <= 1'b0;
      end
    end
  end

  // Flush/redirect sequencer with registered outputs; target doubles as
  // redirect_pc and is cleared on the way back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      target      <= '0;
      flush       <= 1'b0;
      pc_redirect <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take_exc || take_eret) begin
            state  <= S_FLUSH;
            cnt    <= '0;
            target <= take_exc ? handler_address : epc;
            flush  <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (cnt == CNT_LAST) begin
            state       <= S_REDIRECT;
            pc_redirect <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_REDIRECT: begin
          state       <= S_IDLE;
          cnt         <= '0;
          target      <= '0;
          flush       <= 1'b0;
          pc_redirect <= 1'b0;
          busy        <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign redirect_pc = target;
  assign exl         = status_exl;

  // Register read port: current contents, no bypass of a same-cycle write.
  always_comb begin
    // NOTE: the default assignment up front keeps this block free of latches.
    mfc0_rdata = '0;
    case (mfc0_addr)
      REG_STATUS: mfc0_rdata = {30'b0, status_exl, status_ie};
      REG_CAUSE:  mfc0_rdata = {25'b0, cause_code, 2'b00};
      REG_EPC:    mfc0_rdata = epc;
      default:    mfc0_rdata = '0;
    endcase
  end

endmodule
